// File: rtl/act_quant_ctrl.sv
// act_quant_ctrl: per-layer sequencer around an external activation quantizer.
// Issues accumulator vectors, buffers quantized results, flags overflow.
module act_quant_ctrl #(
  parameter int DATA_WIDTH      = 28,
  parameter int MAX_INPUT_WIDTH = 16,
  parameter int CNT_WIDTH       = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [4:0]                            layer_num_i,
  input  logic [CNT_WIDTH-1:0]                  num_vec,
  input  logic                                  cfg_we,
  input  logic [4:0]                            cfg_addr,
  input  logic [4:0]                            cfg_data,
  input  logic                                  in_vld,
  output logic                                  in_rdy,
  input  logic [DATA_WIDTH*MAX_INPUT_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH*MAX_INPUT_WIDTH-1:0] q_din,
  output logic [1:0]                            q_fmap_precision,
  output logic [2:0]                            q_shift,
  output logic [4:0]                            q_layer_num,
  output logic                                  q_vld_i,
  input  logic                                  q_vld_o,
  input  logic [8*MAX_INPUT_WIDTH-1:0]          q_data_o,
  output logic                                  out_vld,
  input  logic                                  out_rdy,
  output logic [8*MAX_INPUT_WIDTH-1:0]          out_data,
  output logic                                  busy,
  output logic                                  layer_done,
  output logic                                  err_ovf
);

  localparam int IW = DATA_WIDTH * MAX_INPUT_WIDTH;
  localparam int OW = 8 * MAX_INPUT_WIDTH;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_RUN, S_DRAIN, S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] nvec_q, nvec_d;
  logic [CNT_WIDTH-1:0] issued_q, issued_d;
  logic [4:0]           layer_q, layer_d;
  logic [CW-1:0]        inflight_q, inflight_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        wr_q, rd_q;
  logic                 err_q;
  logic [4:0]           tbl_q [32];
  logic [OW-1:0]        mem_q [FIFO_DEPTH];
  logic [IW-1:0]        q_din_q;
  logic                 q_vld_q;
  logic [1:0]           prec_q;
  logic [2:0]           shift_q;
  logic [4:0]           qlayer_q;

  logic          hs, full, empty, pop, push, stray, dec;
  logic [CW:0]   occ;

  assign occ    = {1'b0, inflight_q} + {1'b0, cnt_q};
  assign in_rdy = (state_q == S_RUN) && (occ < (CW+1)'(FIFO_DEPTH));
  assign hs     = in_vld && in_rdy;
  assign full   = (cnt_q == CW'(FIFO_DEPTH));
  assign empty  = (cnt_q == '0);
  assign pop    = !empty && out_rdy;
  // A result with nothing outstanding cannot belong to this layer.
  assign stray  = q_vld_o && (inflight_q == '0);
  assign dec    = q_vld_o && !stray;
  assign push   = dec && (!full || pop);

  assign out_vld          = !empty;
  assign out_data         = empty ? '0 : mem_q[rd_q];
  assign busy             = (state_q != S_IDLE);
  assign layer_done       = (state_q == S_DONE);
  assign err_ovf          = err_q;
  assign q_din            = q_din_q;
  assign q_vld_i          = q_vld_q;
  assign q_fmap_precision = prec_q;
  assign q_shift          = shift_q;
  assign q_layer_num      = qlayer_q;

  // Layer sequencing: next state and per-layer counters.
  always_comb begin
    state_d  = state_q;
    nvec_d   = nvec_q;
    layer_d  = layer_q;
    issued_d = issued_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_vec != '0) begin
            nvec_d   = num_vec;
            layer_d  = layer_num_i;
            issued_d = '0;
            state_d  = S_CFG;
          end else begin
            state_d  = S_DONE;
          end
        end
      end
      S_CFG: state_d = S_RUN;
      S_RUN: begin
        if (hs) begin
          issued_d = issued_q + CNT_WIDTH'(1);
          if (issued_d == nvec_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (inflight_q == '0 && empty) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outstanding-vector and buffer occupancy bookkeeping.
  always_comb begin
    inflight_d = inflight_q;
    cnt_d      = cnt_q;
    if (hs && !dec) inflight_d = inflight_q + CW'(1);
    if (!hs && dec) inflight_d = inflight_q - CW'(1);
    if (push && !pop) cnt_d = cnt_q + CW'(1);
    if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  // Control state, counters, pointers and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      nvec_q     <= '0;
      issued_q   <= '0;
      layer_q    <= '0;
      inflight_q <= '0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      nvec_q     <= nvec_d;
      issued_q   <= issued_d;
      layer_q    <= layer_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_q + PW'(push);
      rd_q       <= rd_q + PW'(pop);
      err_q      <= err_q | stray | (q_vld_o && full && !pop);
    end
  end

  // Per-layer config table, writable at any time.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) tbl_q[i] <= '0;
    end else if (cfg_we) begin
      tbl_q[cfg_addr] <= cfg_data;
    end
  end

  // Quantizer issue port; config snapshot taken once per layer in CFG.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_din_q  <= '0;
      q_vld_q  <= 1'b0;
      prec_q   <= '0;
      shift_q  <= '0;
      qlayer_q <= '0;
    end else begin
      q_vld_q <= hs;
      if (hs) q_din_q <= in_data;
      if (state_q == S_CFG) begin
        qlayer_q <= layer_q;
        prec_q   <= tbl_q[layer_q][4:3];
        shift_q  <= tbl_q[layer_q][2:0];
      end
    end
  end

  // Result buffer storage; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= q_data_o;
  end

endmodule

// File: tb/tb_act_quant_ctrl.sv
// tb_act_quant_ctrl: randomized bench with a latency-2 quantizer model
// and an in-order scoreboard of expected quantized vectors.
module tb_act_quant_ctrl;
  localparam int DW = 28;
  localparam int NL = 16;
  localparam int NC = 16;
  localparam int FD = 4;
  localparam int IW = DW * NL;
  localparam int OW = 8 * NL;
  localparam int QL = 2;

  logic clk = 0;
  always #5 clk = ~clk;

  logic          rst = 1, start = 0;
  logic [4:0]    layer_num_i = '0;
  logic [NC-1:0] num_vec = '0;
  logic          cfg_we = 0;
  logic [4:0]    cfg_addr = '0, cfg_data = '0;
  logic          in_vld = 0, in_rdy;
  logic [IW-1:0] in_data = '0, q_din;
  logic [1:0]    q_fmap_precision;
  logic [2:0]    q_shift;
  logic [4:0]    q_layer_num;
  logic          q_vld_i, q_vld_o;
  logic [OW-1:0] q_data_o, out_data;
  logic          out_vld, out_rdy = 0;
  logic          busy, layer_done, err_ovf;

  int checks = 0, errors = 0;
  int qvi_cnt = 0, done_cnt = 0;
  logic [QL-1:0] pv = '0;
  logic [OW-1:0] pd [QL];
  logic          stray = 0;
  logic [4:0]    mtbl [32];
  logic [OW-1:0] exp_q [$];
  logic [OW-1:0] got_q [$];

  act_quant_ctrl #(.DATA_WIDTH(DW), .MAX_INPUT_WIDTH(NL),
                   .CNT_WIDTH(NC), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .start(start), .layer_num_i(layer_num_i),
    .num_vec(num_vec), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_data(in_data), .q_din(q_din),
    .q_fmap_precision(q_fmap_precision), .q_shift(q_shift),
    .q_layer_num(q_layer_num), .q_vld_i(q_vld_i), .q_vld_o(q_vld_o),
    .q_data_o(q_data_o), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_data(out_data), .busy(busy), .layer_done(layer_done),
    .err_ovf(err_ovf)
  );

  function automatic logic [OW-1:0] quant(input logic [IW-1:0] v,
                                          input logic [2:0] sh);
    logic [DW-1:0] lane;
    logic [OW-1:0] o;
    o = '0;
    for (int i = 0; i < NL; i++) begin
      lane = v[i*DW +: DW] >> sh;
      o[i*8 +: 8] = lane[7:0];
    end
    return o;
  endfunction

  function automatic logic [IW-1:0] rand_vec();
    logic [IW-1:0] v;
    v = '0;
    for (int i = 0; i < (IW + 31) / 32; i++) v = (v << 32) | IW'($urandom);
    return v;
  endfunction

  // Quantizer model: fixed latency, shift taken from the DUT config port.
  always @(posedge clk) begin
    pv <= {pv[QL-2:0], q_vld_i};
    pd[0] <= quant(q_din, q_shift);
    for (int i = 1; i < QL; i++) pd[i] <= pd[i-1];
  end
  assign q_vld_o  = pv[QL-1] | stray;
  assign q_data_o = pd[QL-1];

  // Monitor: accepted outputs and event counts.
  always @(posedge clk) begin
    if (out_vld && out_rdy) got_q.push_back(out_data);
    if (q_vld_i) qvi_cnt <= qvi_cnt + 1;
    if (layer_done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1; start = 0; cfg_we = 0; in_vld = 0; out_rdy = 0; stray = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 32; i++) mtbl[i] = '0;
  endtask

  task automatic cfg_write(input logic [4:0] a, input logic [4:0] d);
    @(negedge clk);
    cfg_we = 1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 0;
    mtbl[a] = d;
  endtask

  task automatic start_layer(input logic [4:0] l, input int n);
    @(negedge clk);
    start = 1; layer_num_i = l; num_vec = NC'(n);
    @(negedge clk);
    start = 0;
  endtask

  task automatic drive_layer(input int n, input int vpct, input int rpct,
                             input int budget, input logic [2:0] sh,
                             output bit to);
    int sent, c;
    bit hs, seen;
    logic [IW-1:0] v;
    sent = 0; c = 0; seen = 0;
    v = rand_vec();
    while (!seen && c < budget) begin
      @(negedge clk);
      if (layer_done) begin
        seen = 1;
        in_vld = 0;
      end else begin
        in_vld  = (sent < n) && ($urandom_range(0, 99) < vpct);
        in_data = v;
        out_rdy = ($urandom_range(0, 99) < rpct);
        hs = in_vld && in_rdy;
        @(posedge clk);
        if (hs) begin
          exp_q.push_back(quant(v, sh));
          sent++;
          v = rand_vec();
        end
        c++;
      end
    end
    in_vld = 0;
    to = !seen;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({busy, in_rdy, q_vld_i, out_vld, layer_done, err_ovf, q_shift,
         q_fmap_precision, q_layer_num} !== '0) begin
      errors++;
      $display("FAIL reset_ctl got %b want 0", {busy, in_rdy, q_vld_i,
               out_vld, layer_done, err_ovf, q_shift, q_fmap_precision,
               q_layer_num});
    end
    checks++;
    if (q_din !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_data got q_din %h out_data %h want 0",
               q_din, out_data);
    end
  endtask

  task automatic test_basic();
    int gb, eb, q0, d0;
    bit to;
    cfg_write(5'd13, {2'b01, 3'd4});
    gb = got_q.size(); eb = exp_q.size(); q0 = qvi_cnt; d0 = done_cnt;
    start_layer(5'd13, 3);
    drive_layer(3, 100, 100, 100, 3'd4, to);
    checks++;
    if (layer_done !== 1'b1) begin
      errors++; $display("FAIL basic_done got %b want 1", layer_done);
    end
    @(negedge clk);
    checks++;
    if (layer_done !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse got %b want 0", layer_done);
    end
    @(negedge clk);
    checks++;
    if (to) begin errors++; $display("FAIL basic_timeout got 1 want 0"); end
    checks++;
    if (q_fmap_precision !== 2'd1 || q_shift !== 3'd4 ||
        q_layer_num !== 5'd13) begin
      errors++;
      $display("FAIL basic_cfg got %0d/%0d/%0d want 1/4/13",
               q_fmap_precision, q_shift, q_layer_num);
    end
    checks++;
    if (qvi_cnt - q0 != 3) begin
      errors++; $display("FAIL basic_qvld got %0d want 3", qvi_cnt - q0);
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++; $display("FAIL basic_ndone got %0d want 1", done_cnt - d0);
    end
    checks++;
    if (got_q.size() - gb != 3) begin
      errors++;
      $display("FAIL basic_nout got %0d want 3", got_q.size() - gb);
    end
    for (int i = 0; i < 3; i++) begin
      if (gb + i < got_q.size() && eb + i < exp_q.size()) begin
        checks++;
        if (got_q[gb+i] !== exp_q[eb+i]) begin
          errors++;
          $display("FAIL basic_data[%0d] got %h want %h", i,
                   got_q[gb+i], exp_q[eb+i]);
        end
      end
    end
    checks++;
    if (err_ovf !== 1'b0) begin
      errors++; $display("FAIL basic_err got %b want 0", err_ovf);
    end
  endtask

  task automatic test_backpressure();
    int gb, eb, d0, hsn;
    bit to, hs;
    logic [IW-1:0] v;
    cfg_write(5'd2, {2'b00, 3'd1});
    gb = got_q.size(); eb = exp_q.size(); d0 = done_cnt; hsn = 0;
    start_layer(5'd2, 8);
    v = rand_vec();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_vld = 1; in_data = v; out_rdy = 0;
      hs = in_rdy;
      @(posedge clk);
      if (hs) begin
        exp_q.push_back(quant(v, 3'd1));
        hsn++;
        v = rand_vec();
      end
    end
    @(negedge clk);
    in_vld = 0;
    checks++;
    if (hsn != FD) begin
      errors++; $display("FAIL bp_handshakes got %0d want %0d", hsn, FD);
    end
    checks++;
    if (in_rdy !== 1'b0 || out_vld !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall got rdy %b vld %b want 0 1", in_rdy, out_vld);
    end
    drive_layer(8 - hsn, 100, 100, 200, 3'd1, to);
    repeat (2) @(negedge clk);
    checks++;
    if (to) begin errors++; $display("FAIL bp_timeout got 1 want 0"); end
    checks++;
    if (got_q.size() - gb != 8) begin
      errors++; $display("FAIL bp_nout got %0d want 8", got_q.size() - gb);
    end
    for (int i = 0; i < 8; i++) begin
      if (gb + i < got_q.size() && eb + i < exp_q.size()) begin
        checks++;
        if (got_q[gb+i] !== exp_q[eb+i]) begin
          errors++;
          $display("FAIL bp_data[%0d] got %h want %h", i,
                   got_q[gb+i], exp_q[eb+i]);
        end
      end
    end
    checks++;
    if (err_ovf !== 1'b0 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL bp_end got err %b done %0d want 0 1", err_ovf,
               done_cnt - d0);
    end
  endtask

  task automatic test_zero();
    int q0, d0;
    q0 = qvi_cnt; d0 = done_cnt;
    @(negedge clk);
    start = 1; layer_num_i = 5'd5; num_vec = '0;
    @(negedge clk);
    start = 0;
    checks++;
    if (layer_done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_done got done %b busy %b want 1 1",
               layer_done, busy);
    end
    @(negedge clk);
    checks++;
    if (layer_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_idle got done %b busy %b want 0 0",
               layer_done, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (qvi_cnt != q0 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL zero_counts got qvld %0d done %0d want 0 1",
               qvi_cnt - q0, done_cnt - d0);
    end
  endtask

  task automatic test_cfg_write();
    int gb, eb;
    bit to;
    cfg_write(5'd7, {2'b10, 3'd2});
    gb = got_q.size(); eb = exp_q.size();
    start_layer(5'd7, 6);
    @(negedge clk);
    cfg_we = 1; cfg_addr = 5'd7; cfg_data = {2'b11, 3'd5};
    @(negedge clk);
    cfg_we = 0;
    checks++;
    if (q_fmap_precision !== 2'd2 || q_shift !== 3'd2) begin
      errors++;
      $display("FAIL cfgw_run got %0d/%0d want 2/2", q_fmap_precision,
               q_shift);
    end
    drive_layer(6, 80, 80, 300, 3'd2, to);
    checks++;
    if (to || q_fmap_precision !== 2'd2 || q_shift !== 3'd2) begin
      errors++;
      $display("FAIL cfgw_hold got %0d/%0d to %0d want 2/2 0",
               q_fmap_precision, q_shift, to);
    end
    mtbl[7] = {2'b11, 3'd5};
    @(negedge clk);
    start = 1; layer_num_i = 5'd7; num_vec = NC'(1);
    @(negedge clk);
    start = 0;
    cfg_we = 1; cfg_addr = 5'd7; cfg_data = {2'b01, 3'd6};
    @(negedge clk);
    cfg_we = 0;
    checks++;
    if (q_fmap_precision !== 2'd3 || q_shift !== 3'd5) begin
      errors++;
      $display("FAIL cfgw_next got %0d/%0d want 3/5", q_fmap_precision,
               q_shift);
    end
    drive_layer(1, 100, 100, 50, 3'd5, to);
    mtbl[7] = {2'b01, 3'd6};
    repeat (2) @(negedge clk);
    checks++;
    if (to || got_q.size() - gb != 7) begin
      errors++;
      $display("FAIL cfgw_nout got %0d to %0d want 7 0",
               got_q.size() - gb, to);
    end
    for (int i = 0; i < 7; i++) begin
      if (gb + i < got_q.size() && eb + i < exp_q.size()) begin
        checks++;
        if (got_q[gb+i] !== exp_q[eb+i]) begin
          errors++;
          $display("FAIL cfgw_data[%0d] got %h want %h", i,
                   got_q[gb+i], exp_q[eb+i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int gb, eb, d0, n;
    logic [4:0] l, d;
    bit to;
    for (int k = 0; k < 5; k++) begin
      l = 5'($urandom_range(0, 31));
      d = 5'($urandom);
      cfg_write(l, d);
      n = $urandom_range(1, 12);
      gb = got_q.size(); eb = exp_q.size(); d0 = done_cnt;
      start_layer(l, n);
      drive_layer(n, 70, 60, 600, d[2:0], to);
      repeat (2) @(negedge clk);
      checks++;
      if (to || done_cnt - d0 != 1) begin
        errors++;
        $display("FAIL rnd%0d_done got to %0d done %0d want 0 1", k, to,
                 done_cnt - d0);
      end
      checks++;
      if (q_layer_num !== l || q_shift !== d[2:0] ||
          q_fmap_precision !== d[4:3]) begin
        errors++;
        $display("FAIL rnd%0d_cfg got %0d/%0d/%0d want %0d/%0d/%0d", k,
                 q_layer_num, q_fmap_precision, q_shift, l, d[4:3], d[2:0]);
      end
      checks++;
      if (got_q.size() - gb != n) begin
        errors++;
        $display("FAIL rnd%0d_nout got %0d want %0d", k,
                 got_q.size() - gb, n);
      end
      for (int i = 0; i < n; i++) begin
        if (gb + i < got_q.size() && eb + i < exp_q.size()) begin
          checks++;
          if (got_q[gb+i] !== exp_q[eb+i]) begin
            errors++;
            $display("FAIL rnd%0d_data[%0d] got %h want %h", k, i,
                     got_q[gb+i], exp_q[eb+i]);
          end
        end
      end
      checks++;
      if (err_ovf !== 1'b0) begin
        errors++; $display("FAIL rnd%0d_err got %b want 0", k, err_ovf);
      end
    end
  endtask

  task automatic test_abort();
    int d0;
    cfg_write(5'd9, 5'b01011);
    d0 = done_cnt;
    start_layer(5'd9, 8);
    @(negedge clk);
    out_rdy = 1; in_vld = 1; in_data = rand_vec();
    @(negedge clk);
    in_data = rand_vec();
    @(negedge clk);
    in_vld = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    checks++;
    if ({busy, in_rdy, q_vld_i, out_vld, layer_done, err_ovf, q_shift,
         q_fmap_precision, q_layer_num} !== '0 || q_din !== '0 ||
        out_data !== '0) begin
      errors++;
      $display("FAIL abort_outs got %b q_din %h want 0", {busy, in_rdy,
               q_vld_i, out_vld, layer_done, err_ovf, q_shift,
               q_fmap_precision, q_layer_num}, q_din);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (err_ovf !== 1'b1) begin
      errors++; $display("FAIL abort_err got %b want 1", err_ovf);
    end
    checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_nodone got done %0d busy %b want 0 0",
               done_cnt - d0, busy);
    end
    apply_reset();
    checks++;
    if (err_ovf !== 1'b0) begin
      errors++; $display("FAIL abort_clr got %b want 0", err_ovf);
    end
    @(negedge clk);
    stray = 1;
    @(negedge clk);
    stray = 0;
    @(negedge clk);
    checks++;
    if (err_ovf !== 1'b1) begin
      errors++; $display("FAIL stray_err got %b want 1", err_ovf);
    end
  endtask

  task automatic test_table_reset();
    bit to;
    apply_reset();
    start_layer(5'd9, 1);
    drive_layer(1, 100, 100, 50, mtbl[9][2:0], to);
    checks++;
    if (to || q_shift !== 3'd0 || q_fmap_precision !== 2'd0 ||
        q_layer_num !== 5'd9) begin
      errors++;
      $display("FAIL tblrst got %0d/%0d/%0d to %0d want 0/0/9 0",
               q_fmap_precision, q_shift, q_layer_num, to);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero();
    test_cfg_write();
    test_random();
    test_abort();
    test_table_reset();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/act_quant_ctrl.md
ACT_QUANT_CTRL -- requirements
Module: act_quant_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 28, accumulator lane width.
REQ-002 SHALL have parameter MAX_INPUT_WIDTH, default 16, lanes per vector.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, vector-count width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries (power of 2, >= quantizer latency + 1).
REQ-005 SHALL have ports: clk  in  1  sole clock; rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: start  in  1  layer start pulse; layer_num_i  in  5  layer index; num_vec  in  CNT_WIDTH  vectors in layer.
REQ-007 SHALL have ports: cfg_we  in  1  config write; cfg_addr  in  5  layer index; cfg_data  in  5  {fmap_precision[1:0], shift[2:0]}.
REQ-008 SHALL have ports: in_vld  in  1; in_rdy  out  1; in_data  in  DATA_WIDTH*MAX_INPUT_WIDTH  accumulator vector.
REQ-009 SHALL have ports: q_din  out  DATA_WIDTH*MAX_INPUT_WIDTH; q_fmap_precision  out  2; q_shift  out  3; q_layer_num  out  5; q_vld_i  out  1; q_vld_o  in  1; q_data_o  in  8*MAX_INPUT_WIDTH (quantizer side).
REQ-010 SHALL have ports: out_vld  out  1; out_rdy  in  1; out_data  out  8*MAX_INPUT_WIDTH; busy  out  1; layer_done  out  1; err_ovf  out  1.

Function
REQ-011 SHALL hold a 32x5 config table; cfg_we writes cfg_data at cfg_addr next edge, accepted in any state.
REQ-012 SHALL implement states IDLE, CFG, RUN, DRAIN, DONE; busy = (state != IDLE).
REQ-013 IDLE: start=1 with num_vec!=0 -> CFG, latching num_vec and layer_num_i; start=1 with num_vec==0 -> DONE; start ignored outside IDLE.
REQ-014 CFG: one cycle; registers q_layer_num, q_fmap_precision, q_shift from table entry of latched layer (write in same cycle not visible); -> RUN.
REQ-015 q_* config outputs SHALL stay constant from CFG exit until next CFG; config writes during RUN/DRAIN do not affect them.
REQ-016 RUN: in_rdy = (inflight + fifo_cnt < FIFO_DEPTH); in_rdy=0 in all other states.
REQ-017 On in_vld&&in_rdy: q_din <= in_data, q_vld_i=1 next cycle only (1-cycle issue latency), issued count +1, inflight +1.
REQ-018 inflight SHALL decrement on q_vld_o; simultaneous increment and decrement leaves it unchanged.
REQ-019 When issued count reaches num_vec after a handshake -> DRAIN that edge.
REQ-020 q_vld_o SHALL push q_data_o into FIFO; out_vld = FIFO non-empty; out_data = head entry; pop on out_vld&&out_rdy; simultaneous push/pop keeps fifo_cnt; pointers wrap modulo FIFO_DEPTH.
REQ-021 q_vld_o when FIFO full and no pop SHALL drop data and set err_ovf (sticky until rst); q_vld_o with inflight==0 SHALL also set err_ovf.
REQ-022 DRAIN: -> DONE when inflight==0 and FIFO empty.
REQ-023 DONE: layer_done=1 for exactly one cycle; -> IDLE.

Reset
REQ-024 rst SHALL clear state to IDLE, counters, FIFO pointers, config table, err_ovf; all outputs 0 (out_data/q_din 0) the cycle after rst.
REQ-025 rst mid-RUN/DRAIN SHALL abort the layer with no layer_done; later q_vld_o pulses from the old layer raise err_ovf.

Verification
REQ-026 cfg layer 13 = {2'b01,3'd4}, start layer 13 num_vec=3, in_vld held, out_rdy=1 -> q_precision=1, q_shift=4, 3 q_vld_i pulses, 3 outputs in order, one layer_done.
REQ-027 out_rdy=0, num_vec=8, quantizer latency 2 -> exactly 4 handshakes then in_rdy=0; releasing out_rdy completes all 8 with err_ovf=0.
REQ-028 start with num_vec=0 -> DONE next cycle, layer_done one cycle, no q_vld_i.
REQ-029 cfg_we to the active layer during RUN -> q_* unchanged until next layer start.
REQ-030 rst asserted in RUN with 2 in flight -> IDLE, outputs 0, no layer_done; stray q_vld_o -> err_ovf=1.
